tsm_sbox_share_collector: RTL and testbench
===========================================

Name: tsm_sbox_share_collector

Overview:
- Downstream stage of the second-order masked AES S-box pipeline, which has three register stages.
- Tracks S-box issues through a valid shadow pipeline matched to the S-box latency.
- Captures the three 8-bit output shares of each byte into per-share state buffers. After NBYTES captures, presents the full masked state to the next round stage with a valid/ready handshake.
- Shares are never combined, XORed, or muxed against each other; each share has its own datapath.

Parameters:
- LATENCY, 3: S-box register stages from issue edge to output-valid edge.
- NBYTES, 16: bytes per state block.
- W, 8: bits per share byte.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- in_issue  in  1  upstream presents a byte to the S-box this cycle
- in_ready  out  1  collector can accept another issue
- sb_sh0  in  W  S-box output share 0
- sb_sh1  in  W  S-box output share 1
- sb_sh2  in  W  S-box output share 2
- out_valid  out  1  full masked state available
- out_ready  in  1  downstream accepts state
- out_sh0  out  W*NBYTES  share-0 state, byte i at [W*i+W-1:W*i]
- out_sh1  out  W*NBYTES  share-1 state, same layout
- out_sh2  out  W*NBYTES  share-2 state, same layout
- err_overrun  out  1  sticky: issue attempted while in_ready low

Behaviour:
- Reset:
  - On an edge with rst=1: out_valid=0, err_overrun=0, all out_sh* = 0.
  - Issue counter, capture counter and valid shadow pipe are cleared; state=FILL.
  - Any in-flight bytes are discarded. Their S-box outputs arriving later are not captured.
- States:
  - FILL: accepting issues and capturing.
  - FULL: state held and presented.
- in_ready is combinational: (state==FILL) && (issue_cnt < NBYTES).
- Issue:
  - An edge with in_issue && in_ready increments issue_cnt and shifts 1 into the LATENCY-deep valid shadow pipe. Otherwise a 0 is shifted in.
  - An edge with in_issue && !in_ready sets err_overrun and leaves issue_cnt and the pipe unchanged. err_overrun clears only on rst.
- Capture:
  - A byte issued at edge t has its shares on sb_sh* during the cycle before edge t+LATENCY.
  - The collector writes them at edge t+LATENCY into byte index cap_cnt of out_sh0/1/2 respectively, then increments cap_cnt.
  - Back-to-back issues give one capture per cycle. Gaps are allowed.
- FILL -> FULL: at the edge performing the NBYTES-th capture. out_valid=1 from the following cycle, and out_sh* are stable while out_valid=1.
- FULL -> FILL:
  - At the edge with out_valid && out_ready: out_valid=0 next cycle, and issue_cnt and cap_cnt both return to 0.
  - in_ready rises in that next cycle.
  - out_sh* keep their old contents until overwritten byte by byte.
- Latency: last issue at edge t -> out_valid high in the cycle after edge t+LATENCY. Minimum block time is NBYTES+LATENCY cycles.
- Invariant: cap_cnt <= issue_cnt <= NBYTES. In FULL, no issue is accepted and no capture occurs (the valid pipe is empty by construction).
- rst asserted while out_valid=1: out_valid drops next cycle and the state is discarded.

Test Plan:
- Reset then 16 consecutive issues; sb_shk = byte_index + 16*k at each capture edge. Required: out_valid high exactly 19 cycles after the first issue edge. out_sh0 byte i = i, out_sh1 byte i = 0x10+i, out_sh2 byte i = 0x20+i. in_ready low after the 16th issue.
- Issues with gaps (pattern 1,0,0,1,...). Required: captures occur exactly 3 edges after each issue and bytes are stored in issue order with no holes.
- Hold out_ready=0 for 10 cycles after out_valid. Required: outputs stable and in_ready=0. Raise out_ready: out_valid=0 and in_ready=1 next cycle.
- Assert in_issue during FULL. Required: err_overrun=1 next cycle and stays 1; issue_cnt unchanged; no capture; cleared only by rst.
- Assert rst after 5 issues with 2 in flight. Required: all outputs 0 next cycle; the in-flight S-box outputs are not captured; a subsequent 16-byte block lands at indices 0..15.
- Second block immediately after handshake, with different data. Required: the new out_valid presents only new bytes, all 16 overwritten.

Source files
------------

// File: rtl/tsm_sbox_share_collector.sv
// Collects the three masked S-box output shares into per-share state
// buffers and hands the full masked state downstream with valid/ready.
module tsm_sbox_share_collector #(
   parameter int LATENCY = 3,
   parameter int NBYTES  = 16,
   parameter int W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_issue,
   output logic              in_ready,
   input  logic [W-1:0]      sb_sh0,
   input  logic [W-1:0]      sb_sh1,
   input  logic [W-1:0]      sb_sh2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W*NBYTES-1:0] out_sh0,
   output logic [W*NBYTES-1:0] out_sh1,
   output logic [W*NBYTES-1:0] out_sh2,
   output logic              err_overrun
);

   localparam int CW = $clog2(NBYTES + 1);

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_e;

   state_e              state_q;
   logic [CW-1:0]       issue_cnt_q;
   logic [CW-1:0]       cap_cnt_q;
   logic [LATENCY-1:0]  vpipe_q;
   logic [W*NBYTES-1:0] sh0_q;
   logic [W*NBYTES-1:0] sh1_q;
   logic [W*NBYTES-1:0] sh2_q;
   logic                valid_q;
   logic                err_q;

   logic issue_acc;
   logic cap;

   // Accept a new byte only while filling and before the block is fully issued.
   always_comb begin
      in_ready  = (state_q == FILL) && (issue_cnt_q < CW'(NBYTES));
      issue_acc = in_issue && in_ready;
      cap       = vpipe_q[LATENCY-1];
   end

   // Issue tracking, per-share capture and block handshake FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FILL;
         issue_cnt_q <= '0;
         cap_cnt_q   <= '0;
         vpipe_q     <= '0;
         sh0_q       <= '0;
         sh1_q       <= '0;
         sh2_q       <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         if (in_issue && !in_ready) begin
            err_q <= 1'b1;
         end
         // A rejected issue never enters the shadow pipe, so it is never captured.
         vpipe_q <= {vpipe_q[LATENCY-2:0], issue_acc};
         if (issue_acc) begin
            issue_cnt_q <= issue_cnt_q + 1'b1;
         end
         if (cap) begin
            // Each share is written through its own lane; shares never meet.
            for (int i = 0; i < NBYTES; i++) begin
               if (cap_cnt_q == CW'(i)) begin
                  sh0_q[W*i +: W] <= sb_sh0;
                  sh1_q[W*i +: W] <= sb_sh1;
                  sh2_q[W*i +: W] <= sb_sh2;
               end
            end
            cap_cnt_q <= cap_cnt_q + 1'b1;
            if (cap_cnt_q == CW'(NBYTES - 1)) begin
               state_q <= FULL;
               valid_q <= 1'b1;
            end
         end
         // The valid pipe is empty in FULL, so this cannot race a capture.
         if (valid_q && out_ready) begin
            state_q     <= FILL;
            valid_q     <= 1'b0;
            issue_cnt_q <= '0;
            cap_cnt_q   <= '0;
         end
      end
   end

   assign out_valid   = valid_q;
   assign out_sh0     = sh0_q;
   assign out_sh1     = sh1_q;
   assign out_sh2     = sh2_q;
   assign err_overrun = err_q;

endmodule

// File: tb/tb_tsm_sbox_share_collector.sv
// Directed bench for the masked S-box share collector.
module tb_tsm_sbox_share_collector;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_issue;
   logic         in_ready;
   logic [7:0]   sb_sh0, sb_sh1, sb_sh2;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_sh0, out_sh1, out_sh2;
   logic         err_overrun;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] cur_tag;
   logic [2:0] p_v;
   logic [7:0] p_t0, p_t1, p_t2;

   always #5 clk = ~clk;

   tsm_sbox_share_collector #(.LATENCY(3), .NBYTES(16), .W(8)) dut (
      .clk(clk), .rst(rst),
      .in_issue(in_issue), .in_ready(in_ready),
      .sb_sh0(sb_sh0), .sb_sh1(sb_sh1), .sb_sh2(sb_sh2),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sh0(out_sh0), .out_sh1(out_sh1), .out_sh2(out_sh2),
      .err_overrun(err_overrun)
   );

   // Stand-in 3-stage S-box: every presented byte emerges 3 edges later.
   always @(posedge clk) begin
      p_v  <= {p_v[1:0], in_issue};
      p_t0 <= cur_tag;
      p_t1 <= p_t0;
      p_t2 <= p_t1;
   end

   assign sb_sh0 = p_v[2] ? p_t2          : 8'hEE;
   assign sb_sh1 = p_v[2] ? p_t2 + 8'h10  : 8'hEE;
   assign sb_sh2 = p_v[2] ? p_t2 + 8'h20  : 8'hEE;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] expv(input logic [7:0] base);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = base + 8'(i);
      return r;
   endfunction

   task automatic chk_state(input string tag, input logic [7:0] base);
      chk({tag, "_sh0"}, out_sh0, expv(base));
      chk({tag, "_sh1"}, out_sh1, expv(base + 8'h10));
      chk({tag, "_sh2"}, out_sh2, expv(base + 8'h20));
   endtask

   task automatic run_block(input string tag, input logic [7:0] base);
      int n;
      for (int i = 0; i < 16; i++) begin
         in_issue = 1'b1;
         cur_tag  = base + 8'(i);
         tick();
      end
      in_issue = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, 128'(out_valid), 128'd1);
      chk_state(tag, base);
   endtask

   initial begin
      logic [127:0] cur_state;
      rst       = 1'b1;
      in_issue  = 1'b0;
      out_ready = 1'b0;
      cur_tag   = 8'h00;
      tick();
      tick();
      chk("rst_valid", 128'(out_valid), 128'd0);
      chk("rst_err", 128'(err_overrun), 128'd0);
      chk("rst_sh0", out_sh0, 128'd0);
      chk("rst_sh1", out_sh1, 128'd0);
      chk("rst_sh2", out_sh2, 128'd0);
      rst = 1'b0;
      chk("rst_ready", 128'(in_ready), 128'd1);

      // Block A: 16 back-to-back issues, edges E1..E16.
      for (int i = 0; i < 16; i++) begin
         in_issue = 1'b1;
         cur_tag  = 8'(i);
         tick();
      end
      in_issue = 1'b0;
      chk("a_ready_low", 128'(in_ready), 128'd0);
      tick();
      tick();
      chk("a_valid_e18", 128'(out_valid), 128'd0);
      tick();
      chk("a_valid_e19", 128'(out_valid), 128'd1);
      chk_state("a", 8'h00);

      // Hold with out_ready low for 10 cycles.
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("hold_valid", 128'(out_valid), 128'd1);
         chk("hold_ready", 128'(in_ready), 128'd0);
         chk("hold_sh0", out_sh0, expv(8'h00));
      end

      // Overrun attempt while FULL.
      in_issue = 1'b1;
      cur_tag  = 8'hF0;
      tick();
      in_issue = 1'b0;
      chk("ovr_err", 128'(err_overrun), 128'd1);
      repeat (4) tick();
      chk("ovr_err_sticky", 128'(err_overrun), 128'd1);
      chk("ovr_valid", 128'(out_valid), 128'd1);
      chk_state("ovr", 8'h00);

      // Handshake.
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("hs_valid", 128'(out_valid), 128'd0);
      chk("hs_ready", 128'(in_ready), 128'd1);
      chk("hs_err", 128'(err_overrun), 128'd1);
      chk("hs_keep_sh0", out_sh0, expv(8'h00));

      // Gapped block: issue every third edge, check capture timing per byte.
      for (int k = 0; k < 16; k++) begin
         in_issue = 1'b1;
         cur_tag  = 8'h80 + 8'(k);
         tick();
         in_issue = 1'b0;
         if (k > 0) begin
            cur_state = out_sh0;
            chk("gap_new", 128'(cur_state[8*(k-1) +: 8]), 128'(8'h80 + 8'(k-1)));
         end
         tick();
         tick();
         cur_state = out_sh0;
         chk("gap_old", 128'(cur_state[8*k +: 8]), 128'(8'(k)));
      end
      tick();
      cur_state = out_sh0;
      chk("gap_new_last", 128'(cur_state[127:120]), 128'(8'h8F));
      chk("gap_valid", 128'(out_valid), 128'd1);
      chk_state("gap", 8'h80);

      // Second block immediately after the handshake.
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("b2_ready", 128'(in_ready), 128'd1);
      run_block("b2", 8'h40);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Reset with bytes still in flight: captures at t3..t5, rst at t6.
      for (int i = 0; i < 5; i++) begin
         in_issue = 1'b1;
         cur_tag  = 8'hC0 + 8'(i);
         tick();
      end
      in_issue = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rr_valid", 128'(out_valid), 128'd0);
      chk("rr_err", 128'(err_overrun), 128'd0);
      chk("rr_sh0", out_sh0, 128'd0);
      chk("rr_sh1", out_sh1, 128'd0);
      chk("rr_sh2", out_sh2, 128'd0);
      tick();
      tick();
      chk("rr_nocap_sh0", out_sh0, 128'd0);
      chk("rr_nocap_sh2", out_sh2, 128'd0);
      run_block("b3", 8'h60);

      // Reset while the state is being presented.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rv_valid", 128'(out_valid), 128'd0);
      chk("rv_sh1", out_sh1, 128'd0);
      chk("rv_ready", 128'(in_ready), 128'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
